wb_frame_dma: RTL and testbench

WB_FRAME_DMA -- requirements
Module: wb_frame_dma

---
 rtl/wb_frame_dma.sv | 229 ++++++++++++++++++++++
 tb/tb_wb_frame_dma.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_frame_dma.sv
// wb_frame_dma: single-channel word-copy DMA engine with a Wishbone
// classic master port. Each word is fetched with one read cycle and then
// written with one write cycle. stb/cyc drop for one cycle between
// transfers, so with zero-wait slaves every word takes four cycles.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   start               one-cycle request to begin a copy (IDLE only)
//   src_adr, dst_adr    byte addresses of the first source/destination word
//   len                 number of 32-bit words to copy (0 = immediate done)
//   abort               stop at the next bus acknowledge
//   busy                high while a copy is in progress
//   done                one-cycle pulse when a copy ends (normally or not)
//   err                 sticky: last copy aborted or timed out
//   wb_*                Wishbone classic master signals
//
// Optional feature: define FRAME_DMA_TIMEOUT_EN to give up on a transfer
// whose ack has not arrived after TMO_CYC strobe cycles.
module wb_frame_dma #(
  parameter int LEN_W   = 11,
  parameter int TMO_CYC = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_adr,
  input  logic [31:0]      dst_adr,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  output logic [3:0]       wb_sel_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  input  logic             wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t           state_r;
  logic [31:0]      src_r;
  logic [31:0]      dst_r;
  logic [LEN_W-1:0] count_r;
  logic             abort_pend_r;

  logic ack_s;
  logic abort_s;
  logic last_s;
  logic tmo_s;

  // An ack only counts while we are actually strobing.
  assign ack_s   = wb_stb_o & wb_ack_i;
  // An abort arriving in the same cycle as the ack is honoured immediately.
  assign abort_s = abort_pend_r | abort;
  assign last_s  = (count_r == LEN_W'(1));

`ifdef FRAME_DMA_TIMEOUT_EN
  localparam int TMO_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_r;

  // Fires on the TMO_CYC-th consecutive strobe cycle without an ack.
  assign tmo_s = wb_stb_o & ~wb_ack_i & (tmo_cnt_r == TMO_W'(TMO_CYC - 1));

  // Counts strobe cycles still waiting for ack; cleared whenever stb is low or acked.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r <= TMO_W'(0);
    end else if (wb_stb_o && !wb_ack_i) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= TMO_W'(0);
    end
  end
`else
  assign tmo_s = 1'b0;
`endif

  // Copy engine FSM; all bus and status outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      src_r        <= 32'd0;
      dst_r        <= 32'd0;
      count_r      <= LEN_W'(0);
      abort_pend_r <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      wb_adr_o     <= 32'd0;
      wb_dat_o     <= 32'd0;
      wb_sel_o     <= 4'h0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            src_r   <= src_adr;
            dst_r   <= dst_adr;
            count_r <= len;
            err     <= 1'b0;
            if (len == LEN_W'(0)) begin
              done <= 1'b1;
            end else begin
              state_r  <= READ;
              busy     <= 1'b1;
              wb_adr_o <= src_adr;
              wb_sel_o <= 4'hF;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        READ: begin
          abort_pend_r <= abort_pend_r | abort;
          if (tmo_s) begin
            state_r      <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b1;
            err          <= 1'b1;
            abort_pend_r <= 1'b0;
            wb_sel_o     <= 4'h0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
          end else if (ack_s) begin
            wb_dat_o <= wb_dat_i;
            wb_sel_o <= 4'h0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (abort_s) begin
              // The fetched word is discarded: no write follows.
              state_r      <= IDLE;
              busy         <= 1'b0;
              done         <= 1'b1;
              err          <= 1'b1;
              abort_pend_r <= 1'b0;
            end else begin
              state_r  <= WRITE;
              wb_adr_o <= dst_r;
            end
          end else if (!wb_stb_o) begin
            // Idle gap after the previous write is over; start the read.
            wb_sel_o <= 4'hF;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b0;
          end else begin
            state_r <= READ;
          end
        end

        WRITE: begin
          abort_pend_r <= abort_pend_r | abort;
          if (tmo_s) begin
            state_r      <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b1;
            err          <= 1'b1;
            abort_pend_r <= 1'b0;
            wb_sel_o     <= 4'h0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
          end else if (ack_s) begin
            src_r    <= src_r + 32'd4;
            dst_r    <= dst_r + 32'd4;
            count_r  <= count_r - LEN_W'(1);
            wb_sel_o <= 4'h0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            if (last_s) begin
              // Final word written: a simultaneous abort is moot.
              state_r      <= IDLE;
              busy         <= 1'b0;
              done         <= 1'b1;
              err          <= 1'b0;
              abort_pend_r <= 1'b0;
            end else if (abort_s) begin
              state_r      <= IDLE;
              busy         <= 1'b0;
              done         <= 1'b1;
              err          <= 1'b1;
              abort_pend_r <= 1'b0;
            end else begin
              state_r  <= READ;
              wb_adr_o <= src_r + 32'd4;
            end
          end else if (!wb_stb_o) begin
            // Idle gap after the read is over; start the write.
            wb_sel_o <= 4'hF;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
          end else begin
            state_r <= WRITE;
          end
        end

        default: begin
          state_r      <= IDLE;
          busy         <= 1'b0;
          abort_pend_r <= 1'b0;
          wb_sel_o     <= 4'h0;
          wb_cyc_o     <= 1'b0;
          wb_stb_o     <= 1'b0;
          wb_we_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_frame_dma.sv
// tb_wb_frame_dma: self-checking bench for wb_frame_dma. A behavioural
// Wishbone slave returns a seeded address-derived pattern with a random
// number of wait states; a monitor logs every acknowledged transfer. The
// expected transfer list is computed directly from the copy request.
module tb_wb_frame_dma;
  localparam int LEN_W = 11;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      src_adr;
  logic [31:0]      dst_adr;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      wb_adr_o;
  logic [31:0]      wb_dat_o;
  logic [31:0]      wb_dat_i;
  logic [3:0]       wb_sel_o;
  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic             wb_we_o;
  logic             wb_ack_i;

  wb_frame_dma #(.LEN_W(LEN_W), .TMO_CYC(255)) dut (
    .clk(clk), .reset(reset), .start(start), .src_adr(src_adr),
    .dst_adr(dst_adr), .len(len), .abort(abort), .busy(busy), .done(done),
    .err(err), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_checks = 0;

  // Slave and monitor state
  logic        ack_en;
  int          min_wait;
  int          max_wait;
  logic [31:0] seed;
  int          stb_age;
  int          cur_wait;
  logic        mon_clr;
  logic [31:0] rd_adr [64];
  logic [31:0] wr_adr [64];
  logic [31:0] wr_dat [64];
  int          rd_cnt, wr_cnt, done_cnt, stb_cycles;
  int          stable_err, gap_err, proto_err;
  logic        busy_seen, cyc_seen;
  logic        prev_hold, prev_ack, prev_we;
  logic [31:0] prev_adr, prev_dat;

  function automatic logic [31:0] pat(input logic [31:0] a, input logic [31:0] s);
    return (a * 32'h9E37_79B1) ^ s;
  endfunction

  assign wb_ack_i = ack_en && wb_stb_o && (stb_age >= cur_wait);
  assign wb_dat_i = pat(wb_adr_o, seed);

  always @(posedge clk) begin
    if (wb_stb_o && !wb_ack_i) begin
      stb_age <= stb_age + 1;
    end else begin
      stb_age  <= 0;
      cur_wait <= int'($urandom_range(max_wait, min_wait));
    end
    prev_hold <= wb_stb_o && !wb_ack_i;
    prev_ack  <= wb_stb_o && wb_ack_i;
    prev_adr  <= wb_adr_o;
    prev_we   <= wb_we_o;
    prev_dat  <= wb_dat_o;
    if (mon_clr) begin
      rd_cnt <= 0; wr_cnt <= 0; done_cnt <= 0; stb_cycles <= 0;
      stable_err <= 0; gap_err <= 0; proto_err <= 0;
      busy_seen <= 1'b0; cyc_seen <= 1'b0;
    end else begin
      if (wb_stb_o && wb_ack_i) begin
        if (wb_we_o) begin
          if (wr_cnt < 64) begin
            wr_adr[wr_cnt] <= wb_adr_o;
            wr_dat[wr_cnt] <= wb_dat_o;
          end
          wr_cnt <= wr_cnt + 1;
        end else begin
          if (rd_cnt < 64) rd_adr[rd_cnt] <= wb_adr_o;
          rd_cnt <= rd_cnt + 1;
        end
      end
      if (done) done_cnt <= done_cnt + 1;
      if (wb_stb_o) stb_cycles <= stb_cycles + 1;
      if (busy) busy_seen <= 1'b1;
      if (wb_cyc_o) cyc_seen <= 1'b1;
      if (prev_hold && (!wb_stb_o || wb_adr_o != prev_adr || wb_we_o != prev_we ||
                        (wb_we_o && wb_dat_o != prev_dat)))
        stable_err <= stable_err + 1;
      if (prev_ack && wb_stb_o) gap_err <= gap_err + 1;
      if (wb_stb_o && (!wb_cyc_o || wb_sel_o != 4'hF)) proto_err <= proto_err + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input int n);
    src_adr = s; dst_adr = d; len = LEN_W'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < limit) begin
      @(posedge clk); #1;
      edges++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_logs(input logic [31:0] s, input logic [31:0] d, input int nr, input int nw);
    check("rd_cnt", rd_cnt, nr);
    check("wr_cnt", wr_cnt, nw);
    for (int i = 0; i < nr && i < 64; i++)
      check("rd_adr", rd_adr[i], s + 32'(4 * i));
    for (int i = 0; i < nw && i < 64; i++) begin
      check("wr_adr", wr_adr[i], d + 32'(4 * i));
      check("wr_dat", wr_dat[i], pat(s + 32'(4 * i), seed));
    end
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int wmin, input int wmax);
    int edges;
    min_wait = wmin; max_wait = wmax; seed = $urandom;
    clr_mon();
    do_start(s, d, n);
    wait_done(20 * n + 20, edges);
    if (wmax == 0) check("latency", edges, 4 * n - 1);
    check("err_ok", 32'(err), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'd0);
    check("done_cnt", done_cnt, 1);
    check_logs(s, d, n, n);
    check("stable", stable_err, 0);
    check("gap", gap_err, 0);
    check("proto", proto_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int n;
    reset = 1'b1; start = 1'b0; abort = 1'b0; ack_en = 1'b1;
    min_wait = 0; max_wait = 0; seed = 32'h1234_5678;
    src_adr = 32'd0; dst_adr = 32'd0; len = '0; mon_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; mon_clr = 1'b0;

    // Reset state
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_stb", 32'(wb_stb_o), 32'd0);
    check("rst_we", 32'(wb_we_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_sel", 32'(wb_sel_o), 32'd0);

    // Zero-wait reference copy: done 11 edges after the start edge
    run_copy(32'h0000_1000, 32'h8000_0000, 3, 0, 0);

    // Random wait states, full 16-word frame, then random frames
    run_copy($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, 16, 0, 5);
    for (int r = 0; r < 4; r++)
      run_copy($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
               int'($urandom_range(16, 1)), 0, int'($urandom_range(5, 0)));

    // Address wrap past 2^32
    run_copy(32'hFFFF_FFF8, 32'hFFFF_FFFC, 4, 0, 2);

    // len = 0: immediate done, no bus activity
    clr_mon();
    do_start(32'h40, 32'h80, 0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("len0_pulse", 32'(done), 32'd0);
    check("len0_cyc_seen", 32'(cyc_seen), 32'd0);
    check("len0_busy_seen", 32'(busy_seen), 32'd0);

    // start while busy is ignored
    min_wait = 0; max_wait = 2; seed = $urandom;
    clr_mon();
    do_start(32'h0000_2000, 32'h0000_3000, 4);
    repeat (3) @(posedge clk);
    #1;
    do_start(32'h0000_5000, 32'h0000_6000, 7);
    wait_done(200, edges);
    @(posedge clk); #1;
    check_logs(32'h0000_2000, 32'h0000_3000, 4, 4);
    check("busy_start_done_cnt", done_cnt, 1);

    // Abort during the 2nd read of a 5-word copy (held pending over waits)
    min_wait = 3; max_wait = 3; seed = $urandom;
    clr_mon();
    do_start(32'h0000_0100, 32'h0000_0900, 5);
    n = 0;
    while (!(wb_stb_o && !wb_we_o && wr_cnt == 1) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("abort_window", 32'(n < 100), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(100, edges);
    check("abort_err", 32'(err), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cyc", 32'(wb_cyc_o), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_logs(32'h0000_0100, 32'h0000_0900, 2, 1);
    check("abort_err_sticky", 32'(err), 32'd1);

    // Abort together with the final write ack counts as normal completion
    min_wait = 0; max_wait = 0; seed = $urandom;
    clr_mon();
    do_start(32'h0000_0A00, 32'h0000_0B00, 2);
    n = 0;
    while (!(wb_stb_o && wb_we_o && wr_cnt == 1) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(20, edges);
    check("last_abort_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    check_logs(32'h0000_0A00, 32'h0000_0B00, 2, 2);

    // Reset mid-write, then a fresh copy works
    min_wait = 20; max_wait = 20;
    clr_mon();
    do_start(32'h0000_0C00, 32'h0000_0D00, 3);
    n = 0;
    while (!(wb_stb_o && wb_we_o) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("rstmid_in_write", 32'(wb_we_o), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstmid_cyc", 32'(wb_cyc_o), 32'd0);
    check("rstmid_stb", 32'(wb_stb_o), 32'd0);
    check("rstmid_we", 32'(wb_we_o), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    run_copy(32'h0000_0E00, 32'h0000_0F00, 2, 0, 0);

    // Slave never acks
    ack_en = 1'b0;
    clr_mon();
    do_start(32'h0000_0100, 32'h0000_0200, 1);
`ifdef FRAME_DMA_TIMEOUT_EN
    wait_done(400, edges);
    check("tmo_edges", edges, 255);
    check("tmo_stb_cycles", stb_cycles, 255);
    check("tmo_cyc", 32'(wb_cyc_o), 32'd0);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
`else
    repeat (400) @(posedge clk);
    #1;
    check("noack_cyc", 32'(wb_cyc_o), 32'd1);
    check("noack_stb", 32'(wb_stb_o), 32'd1);
    check("noack_busy", 32'(busy), 32'd1);
    check("noack_done_cnt", done_cnt, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
`endif
    ack_en = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
